// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU that feeds operands LSB first through a single 1-bit logic/add slice.
// Define SERIAL_ALU_OVERFLOW_EN to add a signed-overflow output that is updated with result.

module serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef SERIAL_ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             carry_out_q, carry_out_d;
    logic             zero_q, zero_d;
`ifdef SERIAL_ALU_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic             a0, bx, r_bit, c_next, accept;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        a0     = a_sh_q[0];
        bx     = (op_q == OP_SUB) ? ~b_sh_q[0] : b_sh_q[0];
        r_bit  = 1'b0;
        c_next = 1'b0;
        case (op_q)
            OP_NOT:         r_bit = ~a0;
            OP_AND:         r_bit = a0 & bx;
            OP_OR:          r_bit = a0 | bx;
            OP_XOR:         r_bit = a0 ^ bx;
            OP_ADD, OP_SUB: begin
                r_bit  = a0 ^ bx ^ carry_q;
                c_next = (a0 & bx) | (a0 & carry_q) | (bx & carry_q);
            end
            default:        r_bit = 1'b0;
        endcase
        acc_next = {r_bit, acc_q[WIDTH-1:1]};

        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        result_d    = result_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif

        // The DONE->IDLE edge also samples start so back-to-back operations run every WIDTH+1 cycles.
        accept = start && ((state_q == IDLE) || (state_q == DONE));

        case (state_q)
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = acc_next;
                carry_d = c_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = acc_next;
                    carry_out_d = c_next;
                    zero_d      = (acc_next == '0);
`ifdef SERIAL_ALU_OVERFLOW_EN
                    ovf_d       = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? (carry_q ^ c_next) : 1'b0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = SHIFT;
            a_sh_d  = a;
            b_sh_d  = b;
            op_d    = op;
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = (op == OP_SUB);
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
`ifdef SERIAL_ALU_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
`ifdef SERIAL_ALU_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: randomized scoreboard bench for serial_alu against an arithmetic reference model.
// Exercises the SERIAL_ALU_OVERFLOW_EN flag when that macro is defined.

module tb_serial_alu;

    localparam int W = 8;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out, zero;
    logic [W-1:0] result;
`ifdef SERIAL_ALU_OVERFLOW_EN
    logic         overflow;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t hold = '{res: '0, c: 1'b0, z: 1'b0, v: 1'b0, cyc: 0};
    exp_t got;

    serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
`ifdef SERIAL_ALU_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model written from the arithmetic meaning of each opcode.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int c);
        exp_t       e;
        logic [W:0] s;
        e.res = '0;
        e.c   = 1'b0;
        e.v   = 1'b0;
        e.cyc = c;
        case (o)
            OP_NOT: e.res = ~x;
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_XOR: e.res = x ^ y;
            OP_ADD: begin
                s     = {1'b0, x} + {1'b0, y};
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            OP_SUB: begin
                e.res = x - y;
                e.c   = (x >= y);
                e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse and checks outputs hold steady otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = '{res: '0, c: 1'b0, z: 1'b0, v: 1'b0, cyc: 0};
        end else if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'(0));
            end else begin
                got = sb.pop_front();
                checkOutput("result", 32'(result), 32'(got.res));
                checkOutput("carry_out", 32'(carry_out), 32'(got.c));
                checkOutput("zero", 32'(zero), 32'(got.z));
`ifdef SERIAL_ALU_OVERFLOW_EN
                checkOutput("overflow", 32'(overflow), 32'(got.v));
`endif
                checkOutput("done_latency", 32'(cyc - got.cyc), 32'(W));
                checkOutput("busy_at_done", 32'(busy), 32'(0));
                hold = got;
            end
        end else begin
            checkOutput("result_hold", 32'(result), 32'(hold.res));
            checkOutput("carry_hold", 32'(carry_out), 32'(hold.c));
            checkOutput("zero_hold", 32'(zero), 32'(hold.z));
        end
    end

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 4 * W + 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit pulse);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(o, x, y, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 3'($urandom);
        checkOutput("busy_after_accept", 32'(busy), 32'(1));
        if (pulse) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waitDrain();
    endtask

    initial begin
        logic [2:0] ro;
        int         next_acc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'(0));
        checkOutput("reset_done", 32'(done), 32'(0));
        checkOutput("reset_result", 32'(result), 32'(0));
        checkOutput("reset_carry", 32'(carry_out), 32'(0));
        checkOutput("reset_zero", 32'(zero), 32'(0));
`ifdef SERIAL_ALU_OVERFLOW_EN
        checkOutput("reset_overflow", 32'(overflow), 32'(0));
`endif
        rst_n = 1'b1;

        applyStimulus(OP_ADD, 8'h5A, 8'h3C, 1'b0);
        applyStimulus(OP_SUB, 8'h10, 8'h10, 1'b0);
        applyStimulus(OP_SUB, 8'h00, 8'h01, 1'b0);
        applyStimulus(OP_NOT, 8'hF0, 8'hCC, 1'b0);
        applyStimulus(OP_AND, 8'hF0, 8'hCC, 1'b1);
        applyStimulus(OP_OR,  8'hF0, 8'hCC, 1'b0);
        applyStimulus(OP_XOR, 8'hF0, 8'hCC, 1'b1);
        applyStimulus(3'b110, 8'hF0, 8'hCC, 1'b0);
        applyStimulus(3'b111, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(OP_ADD, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(OP_SUB, 8'h80, 8'h01, 1'b0);
        applyStimulus(OP_SUB, 8'h7F, 8'hFF, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(7));
            applyStimulus(ro, W'($urandom), W'($urandom), (i % 5) == 0);
        end

        // Start held high with operands changing every cycle; accepts land every W+1 edges.
        @(negedge clk);
        next_acc = cyc + 1;
        for (int i = 0; i < 30; i++) begin
            op    = 3'($urandom_range(7));
            a     = W'($urandom);
            b     = W'($urandom);
            start = 1'b1;
            if (cyc + 1 == next_acc) begin
                sb.push_back(model(op, a, b, next_acc));
                next_acc = next_acc + W + 1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        waitDrain();

        // Leave a nonzero result so the abort visibly clears it.
        applyStimulus(OP_OR, 8'hF0, 8'hCC, 1'b0);
        @(negedge clk);
        op    = OP_ADD;
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'(0));
        checkOutput("abort_done", 32'(done), 32'(0));
        checkOutput("abort_result", 32'(result), 32'(0));
        checkOutput("abort_carry", 32'(carry_out), 32'(0));
        checkOutput("abort_zero", 32'(zero), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        applyStimulus(OP_ADD, 8'hFF, 8'h01, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
